spu_issue_scoreboard: RTL

//  Dual-issue hazard scoreboard for the even/odd SPU pipes. Tracks, per architectural

---
 rtl/spu_issue_scoreboard_if.sv | 40 ++++
 rtl/spu_issue_scoreboard.sv | 81 ++++++++
 2 files changed

// File: rtl/spu_issue_scoreboard_if.sv
// Issue-stage bundle for the dual-issue scoreboard: even/odd instruction fields plus
// the stall and per-pipe accept results.
interface spu_issue_scoreboard_if #(
    parameter int unsigned REG_W = 7,
    parameter int unsigned LAT_W = 3
);
    logic             issue_valid_e;
    logic             regwr_e;
    logic [REG_W-1:0] rt_e;
    logic [LAT_W-1:0] lat_e;
    logic [2:0]       src_vld_e;
    logic [REG_W-1:0] ra_e;
    logic [REG_W-1:0] rb_e;
    logic [REG_W-1:0] rc_e;

    logic             issue_valid_o;
    logic             regwr_o;
    logic [REG_W-1:0] rt_o;
    logic [LAT_W-1:0] lat_o;
    logic [2:0]       src_vld_o;
    logic [REG_W-1:0] ra_o;
    logic [REG_W-1:0] rb_o;
    logic [REG_W-1:0] rc_o;

    logic             stall;
    logic             issue_e;
    logic             issue_o;

    modport master (
        output issue_valid_e, regwr_e, rt_e, lat_e, src_vld_e, ra_e, rb_e, rc_e,
        output issue_valid_o, regwr_o, rt_o, lat_o, src_vld_o, ra_o, rb_o, rc_o,
        input  stall, issue_e, issue_o
    );

    modport slave (
        input  issue_valid_e, regwr_e, rt_e, lat_e, src_vld_e, ra_e, rb_e, rc_e,
        input  issue_valid_o, regwr_o, rt_o, lat_o, src_vld_o, ra_o, rb_o, rc_o,
        output stall, issue_e, issue_o
    );
endinterface

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard scoreboard: per-register writeback countdown, RAW/WAW/intra-pair
// stall generation for the even/odd SPU pipes.
module spu_issue_scoreboard #(
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned REG_W    = 7,
    parameter int unsigned LAT_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    spu_issue_scoreboard_if.slave bus,
    output logic [7:0]            pending_cnt
);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [7:0]       pop_cnt;

    logic raw_e, raw_o, waw_e, waw_o, intra, stall_raw;
    logic wr_e, wr_o;

    always_comb begin
        raw_e = (bus.src_vld_e[0] && (cnt_q[bus.ra_e] != '0)) ||
                (bus.src_vld_e[1] && (cnt_q[bus.rb_e] != '0)) ||
                (bus.src_vld_e[2] && (cnt_q[bus.rc_e] != '0));
        raw_o = (bus.src_vld_o[0] && (cnt_q[bus.ra_o] != '0)) ||
                (bus.src_vld_o[1] && (cnt_q[bus.rb_o] != '0)) ||
                (bus.src_vld_o[2] && (cnt_q[bus.rc_o] != '0));
        waw_e = bus.regwr_e && (cnt_q[bus.rt_e] > bus.lat_e);
        waw_o = bus.regwr_o && (cnt_q[bus.rt_o] > bus.lat_o);
        // Only even->odd forwarding within a pair matters: even is older.
        intra = bus.issue_valid_e && bus.regwr_e && (bus.lat_e != '0) && bus.issue_valid_o &&
                ((bus.src_vld_o[0] && (bus.ra_o == bus.rt_e)) ||
                 (bus.src_vld_o[1] && (bus.rb_o == bus.rt_e)) ||
                 (bus.src_vld_o[2] && (bus.rc_o == bus.rt_e)));
        stall_raw = ((raw_e || waw_e) && bus.issue_valid_e) ||
                    ((raw_o || waw_o) && bus.issue_valid_o) || intra;

        bus.stall   = stall_raw && !reset;
        bus.issue_e = bus.issue_valid_e && !stall_raw && !flush && !reset;
        bus.issue_o = bus.issue_valid_o && !stall_raw && !flush && !reset;
        wr_e        = bus.issue_e && bus.regwr_e;
        wr_o        = bus.issue_o && bus.regwr_o;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            if (wr_e && (bus.rt_e == REG_W'(r)) && wr_o && (bus.rt_o == REG_W'(r))) begin
                cnt_d[r] = (bus.lat_e > bus.lat_o) ? bus.lat_e : bus.lat_o;
            end else if (wr_e && (bus.rt_e == REG_W'(r))) begin
                cnt_d[r] = bus.lat_e;
            end else if (wr_o && (bus.rt_o == REG_W'(r))) begin
                cnt_d[r] = bus.lat_o;
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pop_cnt = pop_cnt + 8'(cnt_q[r] != '0);
        end
    end

    // pending_cnt trails cnt by one cycle; reset/flush zero it together with cnt.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            pending_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_cnt <= pop_cnt;
        end
    end

endmodule
